// File: rtl/vpack_pkg.sv
// Shared types and default geometry for the vector lane packer.
package vpack_pkg;

  localparam int VEC_W  = 128;
  localparam int LANE_W = 32;
  localparam int LANES  = VEC_W / LANE_W;

  typedef logic [$clog2(LANES)-1:0] lane_idx_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } vpack_state_t;

endpackage

// File: rtl/vpack_lane_insert.sv
// Combinational lane insert: replaces the N-bit slice selected by idx
// inside a V-bit accumulator with a new scalar word.
module vpack_lane_insert
  import vpack_pkg::*;
#(
  parameter int V     = VEC_W,
  parameter int N     = LANE_W,
  parameter int IDX_W = $clog2(V / N)
) (
  input  logic [V-1:0]     acc,
  input  logic [N-1:0]     word,
  input  logic [IDX_W-1:0] idx,
  output logic [V-1:0]     acc_out
);

  // Pass the accumulator through and overwrite only the addressed lane.
  always_comb begin
    acc_out = acc;
    acc_out[idx*N +: N] = word;
  end

endmodule

// File: rtl/vector_lane_packer.sv
// Packs scalar words, one per handshake, into V-bit vectors (lane 0 in the
// low bits) and presents each finished vector on a registered valid/ready port.
// Optional feature macro: VPACK_PARTIAL_FLUSH_EN -- when defined, an accepted
// word with in_last=1 closes the vector early with out_lanes = lanes written.
module vector_lane_packer
  import vpack_pkg::*;
#(
  parameter int V = VEC_W,
  parameter int N = LANE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [V-1:0]            out_vec,
  output logic [$clog2(V/N):0]    out_lanes,
  output logic [$clog2(V/N)-1:0]  lane_cnt
);

  localparam int LANES_P = V / N;
  localparam int IDX_W   = $clog2(LANES_P);
  localparam int CNT_W   = IDX_W + 1;

  if (V % N != 0) begin : g_bad_geometry
    $error("vector_lane_packer: V must be an integer multiple of N");
  end

  vpack_state_t     state_q, state_d;
  logic [IDX_W-1:0] lane_cnt_q, lane_cnt_d;
  logic [V-1:0]     acc_q, acc_d;
  logic [V-1:0]     out_vec_q, out_vec_d;
  logic [CNT_W-1:0] out_lanes_q, out_lanes_d;
  logic [V-1:0]     acc_ins;
  logic             close_vec;

`ifndef VPACK_PARTIAL_FLUSH_EN
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

  vpack_lane_insert #(
    .V     (V),
    .N     (N),
    .IDX_W (IDX_W)
  ) u_insert (
    .acc     (acc_q),
    .word    (in_data),
    .idx     (lane_cnt_q),
    .acc_out (acc_ins)
  );

  // State, lane counter, accumulator and output registers; reset discards everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      lane_cnt_q  <= '0;
      acc_q       <= '0;
      out_vec_q   <= '0;
      out_lanes_q <= '0;
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      acc_q       <= acc_d;
      out_vec_q   <= out_vec_d;
      out_lanes_q <= out_lanes_d;
    end
  end

  // Next-state logic: fill lanes in FILL, park the finished vector in HOLD.
  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    acc_d       = acc_q;
    out_vec_d   = out_vec_q;
    out_lanes_d = out_lanes_q;
`ifdef VPACK_PARTIAL_FLUSH_EN
    close_vec   = (lane_cnt_q == IDX_W'(LANES_P - 1)) || in_last;
`else
    close_vec   = (lane_cnt_q == IDX_W'(LANES_P - 1));
`endif
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          if (close_vec) begin
            // Accumulator clears so unfilled lanes of the next vector read zero.
            out_vec_d   = acc_ins;
            out_lanes_d = CNT_W'(lane_cnt_q) + CNT_W'(1);
            acc_d       = '0;
            lane_cnt_d  = '0;
            state_d     = HOLD;
          end else begin
            acc_d       = acc_ins;
            lane_cnt_d  = lane_cnt_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign out_vec   = out_vec_q;
  assign out_lanes = out_lanes_q;
  assign lane_cnt  = lane_cnt_q;

endmodule

// File: tb/tb_vector_lane_packer.sv
// Scoreboard bench for vector_lane_packer: a word-queue reference model
// predicts each vector; a negedge monitor compares every DUT output.
module tb_vector_lane_packer;

  localparam int V     = 128;
  localparam int N     = 32;
  localparam int LANES = V / N;

  typedef struct {
    logic [V-1:0] vec;
    int           lanes;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [N-1:0]             in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [V-1:0]             out_vec;
  logic [$clog2(LANES):0]   out_lanes;
  logic [$clog2(LANES)-1:0] lane_cnt;

  int checks = 0;
  int errors = 0;

  exp_t          exp_q[$];
  logic [N-1:0]  part_q[$];

  vector_lane_packer #(.V(V), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_lanes (out_lanes),
    .lane_cnt  (lane_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model and monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    logic  ready_m;
    logic  flush;
    exp_t  e;
    if (rst) begin
      exp_q.delete();
      part_q.delete();
    end else begin
      ready_m = (exp_q.size() == 0);
      chk("in_ready", V'(in_ready), V'(ready_m));
      chk("out_valid", V'(out_valid), V'(!ready_m));
      chk("lane_cnt", V'(lane_cnt), V'(part_q.size()));
      if (!ready_m) begin
        chk("out_vec", out_vec, exp_q[0].vec);
        chk("out_lanes", V'(out_lanes), V'(exp_q[0].lanes));
        if (out_ready) void'(exp_q.pop_front());
      end
      if (ready_m && in_valid) begin
        part_q.push_back(in_data);
`ifdef VPACK_PARTIAL_FLUSH_EN
        flush = (part_q.size() == LANES) || in_last;
`else
        flush = (part_q.size() == LANES);
`endif
        if (flush) begin
          e.vec = '0;
          for (int i = 0; i < part_q.size(); i++) e.vec[i*N +: N] = part_q[i];
          e.lanes = part_q.size();
          exp_q.push_back(e);
          part_q.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) tick();
  endtask

  // Offer a word until accepted; leaves in_valid high for back-to-back streams.
  task automatic send(input logic [N-1:0] d, input logic l);
    int   n;
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_vec", out_vec, '0);
    chk("rst_out_lanes", V'(out_lanes), V'(0));
    chk("rst_in_ready", V'(in_ready), V'(1));
    tick();

    // 1: four back-to-back words, one-cycle latency
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    send(32'h33333333, 1'b0);
    send(32'h44444444, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", V'(out_valid), V'(1));
    chk("t1_vec", out_vec, 128'h44444444_33333333_22222222_11111111);
    chk("t1_lanes", V'(out_lanes), V'(LANES));
    idle(3);

    // 2: back-pressure for five cycles
    out_ready = 1'b0;
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    send(32'h33333333, 1'b0);
    send(32'h44444444, 1'b0);
    in_data = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_vec", out_vec, 128'h44444444_33333333_22222222_11111111);
      chk("t2_hold_ready", V'(in_ready), V'(0));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t2_drop", V'(out_valid), V'(0));
    idle(2);

    // 3: two vectors with in_valid held high throughout
    for (int i = 1; i <= 2 * LANES; i++) send(N'(32'h0000_0100 * i + i), 1'b0);
    idle(4);

    // 4: reset after two accepted words discards them
    send(32'h5555AAAA, 1'b0);
    send(32'h6666BBBB, 1'b0);
    in_valid = 1'b0;
    do_reset();
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    send(32'hC, 1'b0);
    send(32'hD, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_vec", out_vec, 128'h0000000D_0000000C_0000000B_0000000A);
    idle(3);

    // 5: in_last on the second word
    send(32'hDEADBEEF, 1'b0);
    send(32'hCAFEF00D, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
`ifdef VPACK_PARTIAL_FLUSH_EN
    chk("t5_vec", out_vec, 128'h00000000_00000000_CAFEF00D_DEADBEEF);
    chk("t5_lanes", V'(out_lanes), V'(2));
`else
    chk("t5_no_out", V'(out_valid), V'(0));
    idle(2);
    send(32'h01234567, 1'b0);
    send(32'h89ABCDEF, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_vec", out_vec, 128'h89ABCDEF_01234567_CAFEF00D_DEADBEEF);
    chk("t5_lanes", V'(out_lanes), V'(LANES));
`endif
    idle(3);

    // 6: random valid gaps, random back-pressure, occasional in_last
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = $urandom;
      in_last   = ($urandom_range(0, 99) < 10);
      out_ready = ($urandom_range(0, 99) < 65);
      tick();
    end

    // Drain
    out_ready = 1'b1;
    idle(10);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending vectors", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
